vga_pixel_serializer: RTL and testbench

VGA_PIXEL_SERIALIZER -- requirements
Module: vga_pixel_serializer

---
 rtl/vga_pkg.sv | 18 +
 rtl/vga_hold_reg.sv | 47 ++++
 rtl/vga_pixel_serializer.sv | 142 ++++++++++++++
 tb/tb_vga_pixel_serializer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and sizing helpers for the VGA pixel serializer.
package vga_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } shift_state_e;

    function automatic int calc_ppw(input int word_w, input int bpp);
        return word_w / bpp;
    endfunction

    // Pixel index counter width; PPW is at least 2 so this never collapses to 0.
    function automatic int calc_cnt_w(input int word_w, input int bpp);
        return $clog2(calc_ppw(word_w, bpp));
    endfunction

endpackage

// File: rtl/vga_hold_reg.sv
// Single-entry holding stage between VRAM fetch and the pixel shifter.
module vga_hold_reg #(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic [WORD_W-1:0] word_i,
    input  logic              valid_i,
    input  logic              take_i,
    output logic              ready_o,
    output logic [WORD_W-1:0] hold_o,
    output logic              full_o
);

    logic [WORD_W-1:0] hold_q, hold_d;
    logic              full_q, full_d;
    logic              accept;

    // Ready depends only on registered state, so no valid-to-ready path exists.
    assign ready_o = ~full_q & nReset;
    assign accept  = valid_i & ready_o;

    always_comb begin
        hold_d = hold_q;
        full_d = full_q;
        if (take_i) begin
            full_d = 1'b0;
        end else if (accept) begin
            hold_d = word_i;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!nReset) begin
            hold_q <= '0;
            full_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            full_q <= full_d;
        end
    end

    assign hold_o = hold_q;
    assign full_o = full_q;

endmodule

// File: rtl/vga_pixel_serializer.sv
// Turns VRAM words into a BPP-wide pixel stream with horizontal repeat,
// optional inversion and a sticky starvation flag.
module vga_pixel_serializer
    import vga_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int BPP    = 1
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic              vidActive,
    input  logic [1:0]        pixRep,
    input  logic              invert,
    input  logic [WORD_W-1:0] wordIn,
    input  logic              wordValid,
    output logic              wordReady,
    output logic [BPP-1:0]    pixOut,
    output logic              underrun,
    input  logic              clrUnderrun
);

    localparam int PPW   = calc_ppw(WORD_W, BPP);
    localparam int CNT_W = calc_cnt_w(WORD_W, BPP);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PPW - 1);

    shift_state_e      state_q, state_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  pix_idx_q, pix_idx_d;
    logic [1:0]        rep_cnt_q, rep_cnt_d;
    logic [1:0]        rep_lim_q, rep_lim_d;
    logic              underrun_q, underrun_d;

    logic [WORD_W-1:0] hold_word;
    logic              hold_full;
    logic              load;
    logic              set_underrun;

    vga_hold_reg #(
        .WORD_W (WORD_W)
    ) u_hold (
        .clk     (clk),
        .nReset  (nReset),
        .word_i  (wordIn),
        .valid_i (wordValid),
        .take_i  (load),
        .ready_o (wordReady),
        .hold_o  (hold_word),
        .full_o  (hold_full)
    );

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        pix_idx_d    = pix_idx_q;
        rep_cnt_d    = rep_cnt_q;
        rep_lim_d    = rep_lim_q;
        load         = 1'b0;
        set_underrun = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (vidActive && hold_full) begin
                    load = 1'b1;
                end
            end
            RUN: begin
                if (!vidActive) begin
                    // Leaving the visible region drops the word in flight.
                    state_d   = IDLE;
                    shift_d   = '0;
                    pix_idx_d = '0;
                    rep_cnt_d = '0;
                end else if (rep_cnt_q == rep_lim_q) begin
                    if (pix_idx_q == LAST_IDX) begin
                        if (hold_full) begin
                            load = 1'b1;
                        end else begin
                            state_d      = IDLE;
                            shift_d      = '0;
                            pix_idx_d    = '0;
                            rep_cnt_d    = '0;
                            set_underrun = 1'b1;
                        end
                    end else begin
                        rep_cnt_d = '0;
                        pix_idx_d = pix_idx_q + CNT_W'(1);
                        shift_d   = shift_q << BPP;
                    end
                end else begin
                    rep_cnt_d = rep_cnt_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A load always restarts the word, whether from IDLE or back-to-back.
        if (load) begin
            state_d   = RUN;
            shift_d   = hold_word;
            pix_idx_d = '0;
            rep_cnt_d = '0;
            rep_lim_d = pixRep;
        end

        if (set_underrun) begin
            underrun_d = 1'b1;
        end else if (clrUnderrun) begin
            underrun_d = 1'b0;
        end else begin
            underrun_d = underrun_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!nReset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            pix_idx_q  <= '0;
            rep_cnt_q  <= '0;
            rep_lim_q  <= '0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            pix_idx_q  <= pix_idx_d;
            rep_cnt_q  <= rep_cnt_d;
            rep_lim_q  <= rep_lim_d;
            underrun_q <= underrun_d;
        end
    end

    logic run_active;
    assign run_active = (state_q == RUN) && nReset;

    // Blanking is forced to zero and never inverted.
    for (genvar gi = 0; gi < BPP; gi++) begin : g_pix
        assign pixOut[gi] = run_active & (shift_q[WORD_W-BPP+gi] ^ invert);
    end

    assign underrun = underrun_q & nReset;

endmodule

// File: tb/tb_vga_pixel_serializer.sv
// Self-checking bench: a 1-bpp and a 2-bpp serializer driven on a fixed schedule.
module tb_vga_pixel_serializer;

    logic       clk = 1'b0;
    logic       nReset;
    logic       vidActive;
    logic [1:0] pixRep;
    logic       invert;
    logic       clrUnderrun;
    logic [7:0] wordIn;
    logic       wv1, wv2;
    logic       wr1, wr2;
    logic       un1, un2;
    logic [0:0] pix1;
    logic [1:0] pix2;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    vga_pixel_serializer #(.WORD_W(8), .BPP(1)) u_dut1 (
        .clk         (clk),
        .nReset      (nReset),
        .vidActive   (vidActive),
        .pixRep      (pixRep),
        .invert      (invert),
        .wordIn      (wordIn),
        .wordValid   (wv1),
        .wordReady   (wr1),
        .pixOut      (pix1),
        .underrun    (un1),
        .clrUnderrun (clrUnderrun)
    );

    vga_pixel_serializer #(.WORD_W(8), .BPP(2)) u_dut2 (
        .clk         (clk),
        .nReset      (nReset),
        .vidActive   (vidActive),
        .pixRep      (pixRep),
        .invert      (invert),
        .wordIn      (wordIn),
        .wordValid   (wv2),
        .wordReady   (wr2),
        .pixOut      (pix2),
        .underrun    (un2),
        .clrUnderrun (clrUnderrun)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_bits1(input logic [7:0] w, input logic inv);
        for (int i = 7; i >= 0; i--) exp_q.push_back(int'(w[i] ^ inv));
    endtask

    task automatic test_reset();
        nReset = 1'b0; vidActive = 1'b1; wv1 = 1'b1; wv2 = 1'b1;
        wordIn = 8'h55; pixRep = 2'd0; invert = 1'b0; clrUnderrun = 1'b0;
        tick(); tick();
        checks++; if (wr1 !== 1'b0) begin errors++; $display("FAIL reset_ready1: got %b expected 0", wr1); end
        checks++; if (wr2 !== 1'b0) begin errors++; $display("FAIL reset_ready2: got %b expected 0", wr2); end
        checks++; if (pix1 !== 1'b0) begin errors++; $display("FAIL reset_pix1: got %b expected 0", pix1); end
        checks++; if (pix2 !== 2'd0) begin errors++; $display("FAIL reset_pix2: got %0d expected 0", pix2); end
        checks++; if (un1 !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b expected 0", un1); end
        $display("reset: held 2 cycles, ready=%b pix=%b underrun=%b", wr1, pix1, un1);
        nReset = 1'b1; wv1 = 1'b0; wv2 = 1'b0;
        tick();
        checks++; if (wr1 !== 1'b1) begin errors++; $display("FAIL release_ready1: got %b expected 1", wr1); end
        checks++; if (wr2 !== 1'b1) begin errors++; $display("FAIL release_ready2: got %b expected 1", wr2); end
        $display("reset: released, ready=%b", wr1);
    endtask

    task automatic test_single();
        int e;
        wordIn = 8'hA5; wv1 = 1'b1;
        tick();
        wv1 = 1'b0;
        push_bits1(8'hA5, 1'b0);
        checks++; if (pix1 !== 1'b0) begin errors++; $display("FAIL single_latency: got %b expected 0", pix1); end
        for (int i = 0; i < 8; i++) begin
            tick();
            e = exp_q.pop_front();
            checks++;
            if (pix1 !== 1'(e)) begin errors++; $display("FAIL single_pix%0d: got %b expected %0d", i, pix1, e); end
            $display("single: pixel %0d = %b", i, pix1);
        end
        tick();
        checks++; if (pix1 !== 1'b0) begin errors++; $display("FAIL single_blank: got %b expected 0", pix1); end
        checks++; if (un1 !== 1'b1) begin errors++; $display("FAIL single_underrun: got %b expected 1", un1); end
    endtask

    task automatic test_flag();
        int e;
        clrUnderrun = 1'b1; tick(); clrUnderrun = 1'b0;
        checks++; if (un1 !== 1'b0) begin errors++; $display("FAIL flag_clear: got %b expected 0", un1); end
        wordIn = 8'h01; wv1 = 1'b1;
        tick();
        wv1 = 1'b0;
        push_bits1(8'h01, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick();
            e = exp_q.pop_front();
            checks++;
            if (pix1 !== 1'(e)) begin errors++; $display("FAIL flag_pix%0d: got %b expected %0d", i, pix1, e); end
        end
        clrUnderrun = 1'b1;
        tick();
        checks++; if (un1 !== 1'b1) begin errors++; $display("FAIL flag_set_wins: got %b expected 1", un1); end
        $display("flag: set+clear same edge, underrun=%b", un1);
        tick();
        checks++; if (un1 !== 1'b0) begin errors++; $display("FAIL flag_clear_alone: got %b expected 0", un1); end
        $display("flag: clear alone, underrun=%b", un1);
        clrUnderrun = 1'b0;
    endtask

    task automatic test_back_to_back();
        int e;
        wordIn = 8'hFF; wv1 = 1'b1;
        checks++; if (wr1 !== 1'b1) begin errors++; $display("FAIL stream_ready_start: got %b expected 1", wr1); end
        tick();
        wordIn = 8'h00;
        push_bits1(8'hFF, 1'b0);
        push_bits1(8'h00, 1'b0);
        checks++; if (wr1 !== 1'b0) begin errors++; $display("FAIL stream_ready_full: got %b expected 0", wr1); end
        for (int i = 0; i < 16; i++) begin
            tick();
            e = exp_q.pop_front();
            checks++;
            if (pix1 !== 1'(e)) begin errors++; $display("FAIL stream_pix%0d: got %b expected %0d", i, pix1, e); end
            if (i == 0) begin
                checks++; if (wr1 !== 1'b1) begin errors++; $display("FAIL stream_ready_after_load: got %b expected 1", wr1); end
            end
            if (i == 1) begin
                wv1 = 1'b0;
                checks++; if (wr1 !== 1'b0) begin errors++; $display("FAIL stream_ready_second: got %b expected 0", wr1); end
            end
            if (i == 15) begin
                checks++; if (un1 !== 1'b0) begin errors++; $display("FAIL stream_no_underrun: got %b expected 0", un1); end
            end
            $display("stream: pixel %0d = %b", i, pix1);
        end
        tick();
        checks++; if (pix1 !== 1'b0) begin errors++; $display("FAIL stream_end_blank: got %b expected 0", pix1); end
        checks++; if (un1 !== 1'b1) begin errors++; $display("FAIL stream_end_underrun: got %b expected 1", un1); end
        clrUnderrun = 1'b1; tick(); clrUnderrun = 1'b0;
    endtask

    task automatic test_invert_abort();
        int e;
        invert = 1'b1; wordIn = 8'hF0; wv1 = 1'b1;
        tick();
        wordIn = 8'h3C;
        push_bits1(8'hF0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            e = exp_q.pop_front();
            checks++;
            if (pix1 !== 1'(e)) begin errors++; $display("FAIL invert_pix%0d: got %b expected %0d", i, pix1, e); end
            if (i == 1) wv1 = 1'b0;
            $display("invert: pixel %0d = %b", i, pix1);
        end
        vidActive = 1'b0;
        tick();
        exp_q.delete();
        checks++; if (pix1 !== 1'b0) begin errors++; $display("FAIL abort_blank: got %b expected 0", pix1); end
        checks++; if (un1 !== 1'b0) begin errors++; $display("FAIL abort_underrun: got %b expected 0", un1); end
        checks++; if (wr1 !== 1'b0) begin errors++; $display("FAIL abort_hold_kept: got ready %b expected 0", wr1); end
        $display("abort: pix=%b underrun=%b ready=%b", pix1, un1, wr1);
        vidActive = 1'b1; invert = 1'b0;
        push_bits1(8'h3C, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick();
            e = exp_q.pop_front();
            checks++;
            if (pix1 !== 1'(e)) begin errors++; $display("FAIL resume_pix%0d: got %b expected %0d", i, pix1, e); end
        end
        tick();
        checks++; if (un1 !== 1'b1) begin errors++; $display("FAIL resume_underrun: got %b expected 1", un1); end
        clrUnderrun = 1'b1; tick(); clrUnderrun = 1'b0;
    endtask

    task automatic test_repeat();
        int e;
        pixRep = 2'd1; wordIn = 8'b11100100; wv2 = 1'b1;
        tick();
        wordIn = 8'b00011011;
        exp_q.push_back(3); exp_q.push_back(3); exp_q.push_back(2); exp_q.push_back(2);
        exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(0);
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
        for (int i = 0; i < 12; i++) begin
            tick();
            e = exp_q.pop_front();
            checks++;
            if (pix2 !== 2'(e)) begin errors++; $display("FAIL repeat_pix%0d: got %0d expected %0d", i, pix2, e); end
            if (i == 0) pixRep = 2'd0;
            if (i == 1) wv2 = 1'b0;
            $display("repeat: pixel %0d = %0d", i, pix2);
        end
        tick();
        checks++; if (pix2 !== 2'd0) begin errors++; $display("FAIL repeat_blank: got %0d expected 0", pix2); end
        checks++; if (un2 !== 1'b1) begin errors++; $display("FAIL repeat_underrun: got %b expected 1", un2); end
    endtask

    task automatic test_mid_reset();
        int stray;
        vidActive = 1'b1; pixRep = 2'd0; wordIn = 8'hFF; wv1 = 1'b1;
        tick();
        tick();
        checks++; if (pix1 !== 1'b1) begin errors++; $display("FAIL midrst_pix0: got %b expected 1", pix1); end
        tick();
        checks++; if (pix1 !== 1'b1) begin errors++; $display("FAIL midrst_pix1: got %b expected 1", pix1); end
        wv1 = 1'b0; nReset = 1'b0;
        tick();
        checks++; if (pix1 !== 1'b0) begin errors++; $display("FAIL midrst_pix_in_reset: got %b expected 0", pix1); end
        checks++; if (wr1 !== 1'b0) begin errors++; $display("FAIL midrst_ready_in_reset: got %b expected 0", wr1); end
        nReset = 1'b1;
        #1;
        checks++; if (wr1 !== 1'b1) begin errors++; $display("FAIL midrst_hold_discarded: got ready %b expected 1", wr1); end
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (pix1 !== 1'b0) stray++;
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL midrst_no_pixels: got %0d nonzero cycles expected 0", stray); end
        $display("midrst: stray pixels after reset = %0d", stray);
    endtask

    initial begin
        test_reset();
        test_single();
        test_flag();
        test_back_to_back();
        test_invert_abort();
        test_repeat();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
